// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_pkg
//  Description : Shared constants and types for the multicycle controller:
//                4-bit FSM state encoding, ALUControl codes, datapath mux
//                select codes, instruction field codes and the ALU decode
//                helper function.
//  Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // FSM state encoding (also visible on the State debug port)
    localparam logic [3:0] c_st_fetch    = 4'd0;
    localparam logic [3:0] c_st_decode   = 4'd1;
    localparam logic [3:0] c_st_memadr   = 4'd2;
    localparam logic [3:0] c_st_memread  = 4'd3;
    localparam logic [3:0] c_st_memwb    = 4'd4;
    localparam logic [3:0] c_st_memwrite = 4'd5;
    localparam logic [3:0] c_st_executer = 4'd6;
    localparam logic [3:0] c_st_executei = 4'd7;
    localparam logic [3:0] c_st_aluwb    = 4'd8;
    localparam logic [3:0] c_st_branch   = 4'd9;
    localparam logic [3:0] c_st_unknown  = 4'd10;

    typedef enum logic [3:0] {
        FETCH    = c_st_fetch,
        DECODE   = c_st_decode,
        MEMADR   = c_st_memadr,
        MEMREAD  = c_st_memread,
        MEMWB    = c_st_memwb,
        MEMWRITE = c_st_memwrite,
        EXECUTER = c_st_executer,
        EXECUTEI = c_st_executei,
        ALUWB    = c_st_aluwb,
        BRANCH   = c_st_branch,
        UNKNOWN  = c_st_unknown
    } state_t;

    // ALUControl codes
    localparam logic [1:0] c_alu_add = 2'b00;
    localparam logic [1:0] c_alu_sub = 2'b01;
    localparam logic [1:0] c_alu_and = 2'b10;
    localparam logic [1:0] c_alu_orr = 2'b11;

    // ALUSrcA selects
    localparam logic [1:0] c_srca_a  = 2'b00;
    localparam logic [1:0] c_srca_pc = 2'b01;

    // ALUSrcB selects
    localparam logic [1:0] c_srcb_wd   = 2'b00;
    localparam logic [1:0] c_srcb_imm  = 2'b01;
    localparam logic [1:0] c_srcb_four = 2'b10;

    // ResultSrc selects
    localparam logic [1:0] c_res_aluout    = 2'b00;
    localparam logic [1:0] c_res_data      = 2'b01;
    localparam logic [1:0] c_res_aluresult = 2'b10;

    // Instruction Op field
    localparam logic [1:0] c_op_dp  = 2'b00;
    localparam logic [1:0] c_op_mem = 2'b01;
    localparam logic [1:0] c_op_br  = 2'b10;

    // Data-processing cmd field (Funct[4:1])
    localparam logic [3:0] c_cmd_add = 4'b0100;
    localparam logic [3:0] c_cmd_sub = 4'b0010;
    localparam logic [3:0] c_cmd_and = 4'b0000;
    localparam logic [3:0] c_cmd_orr = 4'b1100;

    // Unsupported commands fall back to ADD
    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        logic [1:0] code;
        code = c_alu_add;
        case (cmd)
            c_cmd_add: code = c_alu_add;
            c_cmd_sub: code = c_alu_sub;
            c_cmd_and: code = c_alu_and;
            c_cmd_orr: code = c_alu_orr;
            default:   code = c_alu_add;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// ============================================================================
//  Module      : cond_check
//  Description : Holds the NZCV flags register and evaluates the ARM
//                condition field against it.
//  Ports       : clk        - rising-edge clock
//                reset      - asynchronous active-low reset (flags -> 0000)
//                cond       - Instr[31:28]
//                alu_flags  - NZCV produced by the ALU this cycle
//                upd_nz_req - request to capture N,Z this cycle
//                upd_cv_req - request to capture C,V this cycle
//                cond_ex    - condition passes (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_check (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       upd_nz_req,
    input  logic       upd_cv_req,
    output logic       cond_ex
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       n_flag;
    logic       z_flag;
    logic       c_flag;
    logic       v_flag;

    assign {n_flag, z_flag, c_flag, v_flag} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_flag;                          // EQ
            4'b0001: cond_ex = ~z_flag;                         // NE
            4'b0010: cond_ex = c_flag;                          // CS
            4'b0011: cond_ex = ~c_flag;                         // CC
            4'b0100: cond_ex = n_flag;                          // MI
            4'b0101: cond_ex = ~n_flag;                         // PL
            4'b0110: cond_ex = v_flag;                          // VS
            4'b0111: cond_ex = ~v_flag;                         // VC
            4'b1000: cond_ex = c_flag & ~z_flag;                // HI
            4'b1001: cond_ex = ~c_flag | z_flag;                // LS
            4'b1010: cond_ex = (n_flag == v_flag);              // GE
            4'b1011: cond_ex = (n_flag != v_flag);              // LT
            4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);    // GT
            4'b1101: cond_ex = z_flag | (n_flag != v_flag);     // LE
            4'b1110: cond_ex = 1'b1;                            // AL
            default: cond_ex = 1'b0;                            // 1111 never executes
        endcase
    end

    // A flag-setting instruction whose own condition fails leaves flags intact
    always_comb begin
        flags_d = flags_q;
        if (upd_nz_req && cond_ex) begin
            flags_d[3:2] = alu_flags[3:2];
        end
        if (upd_cv_req && cond_ex) begin
            flags_d[1:0] = alu_flags[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mc_controller
//  Description : Multicycle ARM-subset controller: main FSM, ALU decode and
//                condition-gated write enables. Flags and condition check
//                live in cond_check.
//  Ports       : clk, reset (async active-low), Instr[31:0], ALUFlags[3:0]
//                PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc     (1 bit)
//                RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
//                ALUControl                                       (2 bit)
//                Undef (1 bit), State[3:0] (debug)
//  Config      : MC_CTRL_UNDEF_TRAP_EN - when defined, Op=11 traps into
//                UNKNOWN until reset with Undef=1; otherwise Op=11 is a NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl,
    output logic        Undef,
    output logic [3:0]  State
);

    // Instruction fields
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       rd_is_pc;
    logic       unused_instr_bits;

    assign cond     = Instr[31:28];
    assign op       = Instr[27:26];
    assign funct    = Instr[25:20];
    assign cmd      = funct[4:1];
    assign rd_is_pc = (Instr[15:12] == 4'hF);
    assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

    state_t state_q;
    state_t state_d;

    // Raw per-state controls, before condition gating
    logic next_pc;
    logic branch;
    logic reg_w;
    logic mem_w;
    logic ir_write;
    logic adr_src;
    logic alu_dec;
    logic undef_st;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;

    logic cond_ex;
    logic pcs;
    logic upd_nz_req;
    logic upd_cv_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        next_pc    = 1'b0;
        branch     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        alu_dec    = 1'b0;
        undef_st   = 1'b0;
        alu_src_a  = c_srca_a;
        alu_src_b  = c_srcb_wd;
        result_src = c_res_aluout;
        case (state_q)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_a  = c_srca_pc;
                alu_src_b  = c_srcb_four;
                result_src = c_res_aluresult;
                next_pc    = 1'b1;
                state_d    = DECODE;
            end
            DECODE: begin
                alu_src_a  = c_srca_pc;
                alu_src_b  = c_srcb_four;
                result_src = c_res_aluresult;
                case (op)
                    c_op_mem: state_d = MEMADR;
                    c_op_dp:  state_d = funct[5] ? EXECUTEI : EXECUTER;
                    c_op_br:  state_d = BRANCH;
`ifdef MC_CTRL_UNDEF_TRAP_EN
                    default:  state_d = UNKNOWN;
`else
                    default:  state_d = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                alu_src_b = c_srcb_imm;
                state_d   = funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                result_src = c_res_data;
                reg_w      = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
                state_d = FETCH;
            end
            EXECUTER: begin
                alu_dec = 1'b1;
                state_d = ALUWB;
            end
            EXECUTEI: begin
                alu_src_b = c_srcb_imm;
                alu_dec   = 1'b1;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_w   = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                alu_src_b  = c_srcb_imm;
                result_src = c_res_aluresult;
                branch     = 1'b1;
                state_d    = FETCH;
            end
            UNKNOWN: begin
`ifdef MC_CTRL_UNDEF_TRAP_EN
                // Sticky trap: only reset leaves this state
                undef_st = 1'b1;
                state_d  = UNKNOWN;
`else
                state_d  = FETCH;
`endif
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Flags are written only by flag-setting data-processing ops;
    // C and V are meaningful only for the arithmetic commands
    assign upd_nz_req = alu_dec & funct[0];
    assign upd_cv_req = upd_nz_req & ((cmd == c_cmd_add) | (cmd == c_cmd_sub));

    cond_check u_cond_check (
        .clk        (clk),
        .reset      (reset),
        .cond       (cond),
        .alu_flags  (ALUFlags),
        .upd_nz_req (upd_nz_req),
        .upd_cv_req (upd_cv_req),
        .cond_ex    (cond_ex)
    );

    // A register write to R15 is a PC write, not a register-file write
    assign pcs = branch | (reg_w & rd_is_pc);

    // Write enables are additionally held low while reset is asserted,
    // because the state register already reads FETCH during reset
    assign PCWrite  = reset & (next_pc | (pcs & cond_ex));
    assign RegWrite = reset & reg_w & cond_ex & ~rd_is_pc;
    assign MemWrite = reset & mem_w & cond_ex;
    assign IRWrite  = reset & ir_write;

    assign AdrSrc     = adr_src;
    assign ALUSrcA    = alu_src_a;
    assign ALUSrcB    = alu_src_b;
    assign ResultSrc  = result_src;
    assign ALUControl = alu_dec ? alu_decode(cmd) : c_alu_add;
    assign ImmSrc     = op;
    assign RegSrc     = {(op == c_op_mem), (op == c_op_br)};
    assign State      = state_q;

`ifdef MC_CTRL_UNDEF_TRAP_EN
    assign Undef = reset & undef_st;
`else
    assign Undef = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_controller
//  Description : Self-checking bench for mc_controller. Directed scenarios
//                followed by random instructions, checked cycle by cycle
//                against an instruction-level reference model.
//  Config      : honours MC_CTRL_UNDEF_TRAP_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_controller;
    import mc_ctrl_pkg::*;

`ifdef MC_CTRL_UNDEF_TRAP_EN
    localparam int MAX_OP = 2;
`else
    localparam int MAX_OP = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, Undef;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
    logic [3:0]  State;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .Undef      (Undef),
        .State      (State)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] m_flags;          // model NZCV
    logic       seen_br_pcw;      // PCWrite observed in the last BRANCH
    logic       seen_aluwb_rw;    // RegWrite observed in the last ALUWB
    logic [2:0] seen_memwb;       // {ResultSrc, RegWrite} in the last MEMWB
    logic       seen_memw;        // MemWrite observed in the last MEMWRITE

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ARM condition semantics, flags = {N,Z,C,V}
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_code(input logic [3:0] cmd);
        if (cmd == 4'd4)  return 2'd0;
        if (cmd == 4'd2)  return 2'd1;
        if (cmd == 4'd0)  return 2'd2;
        if (cmd == 4'd12) return 2'd3;
        return 2'd0;
    endfunction

    // Expected {PCWrite, RegWrite, MemWrite, IRWrite}
    function automatic logic [3:0] exp_wr(input state_t s, input logic [31:0] ins, input logic [3:0] fl);
        logic ce, rd15, wb, pcw, rw, mw;
        ce   = cond_ok(ins[31:28], fl);
        rd15 = (ins[15:12] == 4'd15);
        wb   = (s == MEMWB) || (s == ALUWB);
        pcw  = (s == FETCH) || (((s == BRANCH) || (wb && rd15)) && ce);
        rw   = wb && ce && !rd15;
        mw   = (s == MEMWRITE) && ce;
        return {pcw, rw, mw, s == FETCH};
    endfunction

    // Expected {AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Undef}
    function automatic logic [13:0] exp_mux(input state_t s, input logic [31:0] ins);
        logic       adr, und;
        logic [1:0] rs, sa, sb, res, imm, ac;
        adr = (s == MEMREAD) || (s == MEMWRITE);
        rs  = {ins[27:26] == 2'b01, ins[27:26] == 2'b10};
        sa  = ((s == FETCH) || (s == DECODE)) ? 2'b01 : 2'b00;
        if ((s == FETCH) || (s == DECODE))                           sb = 2'b10;
        else if ((s == MEMADR) || (s == EXECUTEI) || (s == BRANCH))  sb = 2'b01;
        else                                                          sb = 2'b00;
        if ((s == FETCH) || (s == DECODE) || (s == BRANCH)) res = 2'b10;
        else if (s == MEMWB)                                res = 2'b01;
        else                                                res = 2'b00;
        imm = ins[27:26];
        ac  = ((s == EXECUTER) || (s == EXECUTEI)) ? alu_code(ins[24:21]) : 2'b00;
        und = (s == UNKNOWN);
        return {adr, rs, sa, sb, res, imm, ac, und};
    endfunction

    function automatic logic [13:0] got_mux();
        return {AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Undef};
    endfunction

    function automatic logic [3:0] got_wr();
        return {PCWrite, RegWrite, MemWrite, IRWrite};
    endfunction

    // Check all outputs in one cycle against the model for state s
    task automatic check_cycle(input state_t s, input logic [31:0] ins);
        check($sformatf("%s/state", s.name()), State, s);
        check($sformatf("%s/wr", s.name()), got_wr(), exp_wr(s, ins, m_flags));
        check($sformatf("%s/mux", s.name()), got_mux(), exp_mux(s, ins));
    endtask

    // Runs one instruction from FETCH. Entered and left at posedge+1.
    // af < 0 drives random ALUFlags, otherwise af[3:0] every cycle.
    task automatic run_instr(input logic [31:0] ins, input int af);
        state_t seq[$];
        seq = {FETCH, DECODE};
        case (ins[27:26])
            2'b00: begin
                seq.push_back(ins[25] ? EXECUTEI : EXECUTER);
                seq.push_back(ALUWB);
            end
            2'b01: begin
                seq.push_back(MEMADR);
                if (ins[20]) begin
                    seq.push_back(MEMREAD);
                    seq.push_back(MEMWB);
                end else begin
                    seq.push_back(MEMWRITE);
                end
            end
            2'b10: seq.push_back(BRANCH);
            default: ;
        endcase
        Instr = ins;
        foreach (seq[i]) begin
            ALUFlags = (af < 0) ? 4'($urandom) : 4'(af);
            @(negedge clk);
            check_cycle(seq[i], ins);
            if (seq[i] == BRANCH)   seen_br_pcw   = PCWrite;
            if (seq[i] == ALUWB)    seen_aluwb_rw = RegWrite;
            if (seq[i] == MEMWB)    seen_memwb    = {ResultSrc, RegWrite};
            if (seq[i] == MEMWRITE) seen_memw     = MemWrite;
            if (((seq[i] == EXECUTER) || (seq[i] == EXECUTEI)) && ins[20]
                && cond_ok(ins[31:28], m_flags)) begin
                m_flags[3:2] = ALUFlags[3:2];
                if ((ins[24:21] == 4'd4) || (ins[24:21] == 4'd2)) m_flags[1:0] = ALUFlags[1:0];
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ins;
        reset    = 1'b0;
        Instr    = 32'h0;
        ALUFlags = 4'b0;
        m_flags  = 4'b0;
        seen_br_pcw = 1'b0; seen_aluwb_rw = 1'b0; seen_memwb = 3'b0; seen_memw = 1'b0;

        // Reset state: FETCH with every write enable forced low
        repeat (2) @(negedge clk);
        check("rst/state", State, FETCH);
        check("rst/wr", got_wr(), 4'b0000);
        check("rst/undef", Undef, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;

        // ADD R1,R1,#5
        run_instr(32'hE2811005, -1);
        check("add/aluwb_rw", seen_aluwb_rw, 1'b1);
        // LDR then STR
        run_instr(32'hE5912000, -1);
        check("ldr/memwb", seen_memwb, 3'b011);
        run_instr(32'hE5812000, -1);
        check("str/memw", seen_memw, 1'b1);
        // SUBS sets Z, BEQ taken
        run_instr(32'hE0500001, 4'b0100);
        run_instr(32'h0A000002, -1);
        check("beq_z1/pcw", seen_br_pcw, 1'b1);
        // SUBS clears Z, BEQ not taken
        run_instr(32'hE0500001, 4'b0000);
        run_instr(32'h0A000002, -1);
        check("beq_z0/pcw", seen_br_pcw, 1'b0);
        // ADDNE with Z=1: no write, flags untouched (BEQ still taken)
        run_instr(32'hE0500001, 4'b0100);
        run_instr(32'h1281100F, 4'b0000);
        check("addne/aluwb_rw", seen_aluwb_rw, 1'b0);
        run_instr(32'h0A000002, -1);
        check("addne/flags_kept", seen_br_pcw, 1'b1);

        // Reset asserted during MEMWRITE
        Instr = 32'hE5812000;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("midrst/pre_state", State, MEMWRITE);
        check("midrst/pre_memw", MemWrite, 1'b1);
        #1 reset = 1'b0;
        #1;
        check("midrst/memw", MemWrite, 1'b0);
        check("midrst/state", State, FETCH);
        m_flags = 4'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        run_instr(32'hE5812000, -1);

        // Random instructions
        for (int k = 0; k < 200; k++) begin
            ins = $urandom;
            ins[27:26] = 2'($urandom_range(0, MAX_OP));
            if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
            if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
            run_instr(ins, -1);
        end

        // Op = 11
`ifdef MC_CTRL_UNDEF_TRAP_EN
        run_instr(32'hEC000000, -1);
        repeat (4) begin
            @(negedge clk);
            check_cycle(UNKNOWN, 32'hEC000000);
            @(posedge clk); #1;
        end
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("undef_rst/state", State, FETCH);
        check("undef_rst/undef", Undef, 1'b0);
        m_flags = 4'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        run_instr(32'hE2811005, -1);
`else
        run_instr(32'hEC000000, -1);
        run_instr(32'hE2811005, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
